// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the multi-channel frequency meter.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_ARM,
    S_GATE,
    S_CLOSE,
    S_DIV,
    S_OUT
  } state_t;

  localparam int unsigned FLAG_W = 2;

  typedef struct packed {
    logic ovf;
    logic nosig;
  } res_flags_t;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned     r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < value) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_div_serial.sv
// Generic restoring divider: one quotient bit per cycle, truncating, done pulses after NUM_W steps.
module freq_div_serial
  import freq_meter_pkg::*;
#(
  parameter int unsigned NUM_W = 42,
  parameter int unsigned DEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quo,
  output logic             done
);

  localparam int unsigned CW = clog2(NUM_W + 1);

  logic [DEN_W:0]   rem;
  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   rem_nxt;
  logic [NUM_W-1:0] q;
  logic [CW-1:0]    cnt;
  logic             running;
  logic             ge;

  // Remainder stays below den, so one extra bit holds the shifted trial value.
  always_comb begin
    shifted = {rem[DEN_W-1:0], q[NUM_W-1]};
    ge      = (shifted >= {1'b0, den});
    rem_nxt = ge ? (shifted - {1'b0, den}) : shifted;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem     <= '0;
        q       <= num;
        cnt     <= CW'(NUM_W);
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_nxt;
        q   <= {q[NUM_W-2:0], ge};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quo = q;

endmodule

// File: rtl/freq_meter_mc.sv
// Multi-channel equal-precision frequency meter: round-robin channel scan, edge-aligned gate,
// serial division f = CLK_FS*Nx/Ns, saturated result over a valid/ready handshake.
module freq_meter_mc
  import freq_meter_pkg::*;
#(
  parameter int unsigned  CH_NUM   = 4,
  parameter int unsigned  CLK_FS   = 100_000_000,
  parameter int unsigned  GATE_CYC = 25_000_000,
  parameter int unsigned  TIMEOUT  = 50_000_000,
  parameter int unsigned  CNT_W    = 32,
  parameter int unsigned  OUT_W    = 20,
  localparam int unsigned CH_W     = (CH_NUM > 1) ? clog2(CH_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] fx_in,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic              cont,
  input  logic              start,
  output logic [OUT_W-1:0]  freq_data,
  output logic [CH_W-1:0]   freq_ch,
  output logic              freq_ovf,
  output logic              freq_nosig,
  output logic              freq_valid,
  input  logic              freq_ready,
  output logic              busy
);

  localparam int unsigned NUM_W = CNT_W + clog2(CLK_FS + 1);
  localparam int unsigned GC_W  = clog2(GATE_CYC + 1);
  localparam int unsigned TO_W  = clog2(TIMEOUT + 1);

  state_t            state;
  logic [CH_NUM-1:0] fx_s0, fx_s1, fx_d;
  logic [CH_NUM-1:0] rise;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   nxt_ch;
  logic              fresh;
  logic              single;
  logic              more_above;
  logic [CNT_W-1:0]  ns, nx;
  logic [GC_W-1:0]   gate_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              sel_rise;
  logic              to_hit;
  logic              cnt_sat;
  logic              div_start;
  logic              div_done;
  logic [NUM_W-1:0]  div_num;
  logic [NUM_W-1:0]  div_quo;
  res_flags_t        flags;

  assign rise     = fx_s1 & ~fx_d;
  assign sel_rise = rise[ptr];
  assign to_hit   = (to_cnt == TO_W'(TIMEOUT - 1)) && !sel_rise;
  assign cnt_sat  = (&ns) || (&nx);
  assign div_num  = NUM_W'(nx) * NUM_W'(CLK_FS);

  // A fresh scan searches from channel 0 inclusive; otherwise from the channel after ptr.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic        found;
    nxt_ch     = ptr;
    found      = 1'b0;
    more_above = 1'b0;
    base       = fresh ? 0 : 32'(ptr) + 1;
    idx        = 0;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      idx = base + k;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (ch_en[idx] && !found) begin
        found  = 1'b1;
        nxt_ch = CH_W'(idx);
      end
      if (ch_en[k] && (k > 32'(ptr))) more_above = 1'b1;
    end
  end

  freq_div_serial #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W)
  ) u_div (
    .clk  (sys_clk),
    .rst_n(rst_n),
    .start(div_start),
    .num  (div_num),
    .den  (ns),
    .quo  (div_quo),
    .done (div_done)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      fx_s0      <= '0;
      fx_s1      <= '0;
      fx_d       <= '0;
      state      <= S_IDLE;
      ptr        <= '0;
      fresh      <= 1'b0;
      single     <= 1'b0;
      ns         <= '0;
      nx         <= '0;
      gate_cnt   <= '0;
      to_cnt     <= '0;
      div_start  <= 1'b0;
      freq_data  <= '0;
      freq_ch    <= '0;
      flags      <= '0;
      freq_valid <= 1'b0;
    end else begin
      fx_s0     <= fx_in;
      fx_s1     <= fx_s0;
      fx_d      <= fx_s1;
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || (cont && (|ch_en))) begin
            state  <= S_SEL;
            fresh  <= 1'b1;
            single <= ~cont;
          end
        end
        S_SEL: begin
          if (ch_en == '0) begin
            state <= S_IDLE;
          end else begin
            ptr    <= nxt_ch;
            fresh  <= 1'b0;
            to_cnt <= '0;
            state  <= S_ARM;
          end
        end
        S_ARM: begin
          if (sel_rise) begin
            ns       <= '0;
            nx       <= '0;
            gate_cnt <= '0;
            to_cnt   <= '0;
            state    <= S_GATE;
          end else if (to_hit) begin
            freq_data  <= '0;
            freq_ch    <= ptr;
            flags      <= '{ovf: 1'b0, nosig: 1'b1};
            freq_valid <= 1'b1;
            state      <= S_OUT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_GATE, S_CLOSE: begin
          if (cnt_sat) begin
            freq_data  <= '1;
            freq_ch    <= ptr;
            flags      <= '{ovf: 1'b1, nosig: 1'b0};
            freq_valid <= 1'b1;
            state      <= S_OUT;
          end else if (to_hit) begin
            freq_data  <= '0;
            freq_ch    <= ptr;
            flags      <= '{ovf: 1'b0, nosig: 1'b1};
            freq_valid <= 1'b1;
            state      <= S_OUT;
          end else begin
            ns     <= ns + CNT_W'(1);
            nx     <= nx + CNT_W'(sel_rise);
            to_cnt <= sel_rise ? '0 : to_cnt + TO_W'(1);
            if (state == S_GATE) begin
              gate_cnt <= gate_cnt + GC_W'(1);
              if (gate_cnt == GC_W'(GATE_CYC - 1)) state <= S_CLOSE;
            end else if (sel_rise) begin
              div_start <= 1'b1;
              state     <= S_DIV;
            end
          end
        end
        S_DIV: begin
          if (div_done) begin
            if (|div_quo[NUM_W-1:OUT_W]) begin
              freq_data <= '1;
              flags     <= '{ovf: 1'b1, nosig: 1'b0};
            end else begin
              freq_data <= div_quo[OUT_W-1:0];
              flags     <= '{ovf: 1'b0, nosig: 1'b0};
            end
            freq_ch    <= ptr;
            freq_valid <= 1'b1;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (freq_ready) begin
            freq_valid <= 1'b0;
            state      <= (cont || (single && more_above)) ? S_SEL : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign freq_ovf   = flags.ovf;
  assign freq_nosig = flags.nosig;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed self-checking bench for freq_meter_mc with scaled-down timing parameters.
module tb_freq_meter_mc;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  fx    = '0;
  logic [3:0]  ch_en = '0;
  logic        cont  = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [19:0] data;
  logic [1:0]  ch;
  logic        ovf, nosig, valid, busy;

  logic [3:0]  ch_en2 = '0;
  logic        cont2  = 1'b0;
  logic        start2 = 1'b0;
  logic        ready2 = 1'b1;
  logic [5:0]  data2;
  logic [1:0]  ch2;
  logic        ovf2, nosig2, valid2, busy2;

  int passed = 0;
  int total  = 0;
  int per[4] = '{0, 0, 0, 0};
  int pc[4]  = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  // Periodic square waves, per[i] cycles per period, 0 holds the line low.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (per[i] == 0) begin
        fx[i] <= 1'b0;
        pc[i] <= 0;
      end else begin
        fx[i] <= (pc[i] < per[i] / 2);
        pc[i] <= (pc[i] + 1 >= per[i]) ? 0 : pc[i] + 1;
      end
    end
  end

  freq_meter_mc #(
    .CH_NUM(4), .CLK_FS(1000), .GATE_CYC(100), .TIMEOUT(300), .CNT_W(32), .OUT_W(20)
  ) dut (
    .sys_clk(clk), .rst_n(rst_n), .fx_in(fx), .ch_en(ch_en), .cont(cont), .start(start),
    .freq_data(data), .freq_ch(ch), .freq_ovf(ovf), .freq_nosig(nosig),
    .freq_valid(valid), .freq_ready(ready), .busy(busy)
  );

  freq_meter_mc #(
    .CH_NUM(4), .CLK_FS(1000), .GATE_CYC(100), .TIMEOUT(300), .CNT_W(32), .OUT_W(6)
  ) dut_sat (
    .sys_clk(clk), .rst_n(rst_n), .fx_in(fx), .ch_en(ch_en2), .cont(cont2), .start(start2),
    .freq_data(data2), .freq_ch(ch2), .freq_ovf(ovf2), .freq_nosig(nosig2),
    .freq_valid(valid2), .freq_ready(ready2), .busy(busy2)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int waited);
    waited = 0;
    while (waited < budget && valid !== 1'b1) begin
      @(negedge clk);
      waited++;
    end
    ok = (valid === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({data, ch, ovf, nosig, valid} !== '0)
      $display("FAIL reset_outputs got %h exp 0", {data, ch, ovf, nosig, valid});
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit seen;
    per[0] = 10; ch_en = 4'b0001; cont = 1'b0; ready = 1'b1;
    pulse_start();
    repeat (60) @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL abort_pre_busy got %b exp 1", busy);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy);
    else passed++;
    total++;
    if (valid !== 1'b0) $display("FAIL abort_valid got %b exp 0", valid);
    else passed++;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL abort_no_result got valid=1 exp no result");
    else passed++;
  endtask

  task automatic test_single();
    bit ok;
    int waited;
    bit seen;
    per[0] = 10; ch_en = 4'b0001; cont = 1'b0; ready = 1'b1;
    pulse_start();
    wait_valid(2000, ok, waited);
    total++;
    if (!ok) $display("FAIL single_timeout got no valid after %0d cycles exp valid", waited);
    else passed++;
    total++;
    if (ch !== 2'd0) $display("FAIL single_ch got %0d exp 0", ch);
    else passed++;
    total++;
    if (data !== 20'd100) $display("FAIL single_data got %0d exp 100", data);
    else passed++;
    total++;
    if ({ovf, nosig} !== 2'b00) $display("FAIL single_flags got %b exp 00", {ovf, nosig});
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL single_idle got busy=%b exp 0", busy);
    else passed++;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL single_one_result got extra activity exp idle");
    else passed++;
  endtask

  task automatic test_continuous();
    bit ok;
    int waited;
    logic [1:0]  exp_ch[5]   = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1};
    logic [19:0] exp_data[5] = '{20'd250, 20'd125, 20'd250, 20'd125, 20'd250};
    per[0] = 0; per[1] = 4; per[3] = 8; ch_en = 4'b1010; ready = 1'b1;
    cont = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_valid(2000, ok, waited);
      total++;
      if (!ok) $display("FAIL cont_timeout[%0d] got no valid after %0d cycles exp valid", n, waited);
      else passed++;
      total++;
      if (ch !== exp_ch[n] || data !== exp_data[n])
        $display("FAIL cont_result[%0d] got ch=%0d data=%0d exp ch=%0d data=%0d",
                 n, ch, data, exp_ch[n], exp_data[n]);
      else passed++;
      @(negedge clk);
      if (n == 3) cont = 1'b0;
    end
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL cont_drop_idle got busy=%b exp 0", busy);
    else passed++;
    per[1] = 0; per[3] = 0;
  endtask

  task automatic test_nosig();
    bit ok;
    int waited;
    per[2] = 0; ch_en = 4'b0100; cont = 1'b0; ready = 1'b1;
    pulse_start();
    wait_valid(1000, ok, waited);
    total++;
    if (!ok) $display("FAIL nosig_timeout got no valid after %0d cycles exp valid", waited);
    else passed++;
    total++;
    if (waited < 300 || waited > 320) $display("FAIL nosig_latency got %0d exp 300..320", waited);
    else passed++;
    total++;
    if (ch !== 2'd2 || data !== 20'd0) $display("FAIL nosig_result got ch=%0d data=%0d exp ch=2 data=0", ch, data);
    else passed++;
    total++;
    if ({ovf, nosig} !== 2'b01) $display("FAIL nosig_flags got %b exp 01", {ovf, nosig});
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturation();
    int waited;
    per[0] = 10; ch_en2 = 4'b0001;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    waited = 0;
    while (waited < 2000 && valid2 !== 1'b1) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (valid2 !== 1'b1) $display("FAIL sat_timeout got no valid after %0d cycles exp valid", waited);
    else passed++;
    total++;
    if (data2 !== 6'd63 || ch2 !== 2'd0) $display("FAIL sat_data got ch=%0d data=%0d exp ch=0 data=63", ch2, data2);
    else passed++;
    total++;
    if ({ovf2, nosig2} !== 2'b10) $display("FAIL sat_flags got %b exp 10", {ovf2, nosig2});
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (busy2 !== 1'b0) $display("FAIL sat_idle got busy=%b exp 0", busy2);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int waited;
    int bad;
    per[0] = 10; ch_en = 4'b0001; ready = 1'b0; cont = 1'b1;
    wait_valid(2000, ok, waited);
    total++;
    if (!ok || data !== 20'd100) $display("FAIL bp_first got valid=%b data=%0d exp valid=1 data=100", valid, data);
    else passed++;
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      total++;
      if ({valid, busy, ch, data} !== {1'b1, 1'b1, 2'd0, 20'd100}) begin
        $display("FAIL bp_hold[%0d] got valid=%b busy=%b ch=%0d data=%0d exp 1 1 0 100", n, valid, busy, ch, data);
        bad++;
      end else passed++;
    end
    ready = 1'b1;
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || busy !== 1'b1) $display("FAIL bp_release got valid=%b busy=%b exp 0 1", valid, busy);
    else passed++;
    cont = 1'b0;
    wait_valid(2000, ok, waited);
    total++;
    if (!ok || data !== 20'd100) $display("FAIL bp_resume got valid=%b data=%0d exp valid=1 data=100", valid, data);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL bp_idle got busy=%b exp 0", busy);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_abort();
    test_single();
    test_continuous();
    test_nosig();
    test_saturation();
    test_backpressure();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
